// File: rtl/debug_ram_sequencer.sv
// rtl/debug_ram_sequencer.sv - debug-port bulk load/dump sequencer for InstRAM/DataRAM
module debug_ram_sequencer #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 13,
    parameter int RD_LAT = 1
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic             cmd_sel,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [31:0]      wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [31:0]      rdata,
    output logic             done,
    output logic             core_hold,
    output logic [31:0]      dram_a2,
    output logic [31:0]      dram_wd2,
    output logic [3:0]       dram_we2,
    input  logic [31:0]      dram_rd2,
    output logic [31:0]      iram_a2,
    output logic [31:0]      iram_wd2,
    output logic [3:0]       iram_we2,
    input  logic [31:0]      iram_rd2
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_DATA, S_WR_COMMIT, S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_sel, w_sel_nxt;
    logic [1:0]        r_lat;
    logic [31:0]       r_rdata;
    logic [31:0]       r_dram_a2, r_dram_wd2, r_iram_a2, r_iram_wd2;
    logic [3:0]        r_dram_we2, r_iram_we2;
    logic              w_lat_last, w_busy_nxt, w_commit_nxt;
    logic [31:0]       w_a2_nxt;
    logic              w_unused_addr;

    assign w_unused_addr = ^{cmd_addr[31:ADDR_W], cmd_addr[1:0]};
    assign w_lat_last    = (r_lat == 2'(RD_LAT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        case (r_state)
            S_IDLE: if (cmd_valid) begin
                w_sel_nxt  = cmd_sel;
                w_addr_nxt = {cmd_addr[ADDR_W-1:2], 2'b00};
                w_cnt_nxt  = cmd_len;
                if (cmd_len == '0)  w_state_nxt = S_DONE;
                else if (cmd_op)    w_state_nxt = S_RD_ADDR;
                else                w_state_nxt = S_WR_DATA;
            end
            S_WR_DATA: if (wdata_valid) w_state_nxt = S_WR_COMMIT;
            S_WR_COMMIT: begin
                w_addr_nxt  = r_addr + ADDR_W'(4);
                w_cnt_nxt   = r_cnt - LEN_W'(1);
                w_state_nxt = (w_cnt_nxt == '0) ? S_DONE : S_WR_DATA;
            end
            S_RD_ADDR: w_state_nxt = S_RD_WAIT;
            S_RD_WAIT: if (w_lat_last) w_state_nxt = S_RD_OUT;
            S_RD_OUT: if (rdata_ready) begin
                w_addr_nxt  = r_addr + ADDR_W'(4);
                w_cnt_nxt   = r_cnt - LEN_W'(1);
                w_state_nxt = (w_cnt_nxt == '0) ? S_DONE : S_RD_ADDR;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // RAM-side ports are registered from the next state so the commit cycle carries A2/WD2/WE2 together
    assign w_busy_nxt   = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    assign w_commit_nxt = (w_state_nxt == S_WR_COMMIT);
    assign w_a2_nxt     = {{(32-ADDR_W){1'b0}}, w_addr_nxt};

    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_sel      <= 1'b0;
            r_lat      <= '0;
            r_rdata    <= '0;
            r_dram_a2  <= '0;
            r_dram_wd2 <= '0;
            r_dram_we2 <= '0;
            r_iram_a2  <= '0;
            r_iram_wd2 <= '0;
            r_iram_we2 <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_lat      <= (r_state == S_RD_WAIT) ? r_lat + 2'd1 : 2'd0;
            if (r_state == S_RD_WAIT && w_lat_last)
                r_rdata <= r_sel ? iram_rd2 : dram_rd2;
            r_dram_a2  <= (w_busy_nxt && !w_sel_nxt)   ? w_a2_nxt : '0;
            r_dram_wd2 <= (w_commit_nxt && !w_sel_nxt) ? wdata    : '0;
            r_dram_we2 <= (w_commit_nxt && !w_sel_nxt) ? 4'hF     : 4'h0;
            r_iram_a2  <= (w_busy_nxt && w_sel_nxt)    ? w_a2_nxt : '0;
            r_iram_wd2 <= (w_commit_nxt && w_sel_nxt)  ? wdata    : '0;
            r_iram_we2 <= (w_commit_nxt && w_sel_nxt)  ? 4'hF     : 4'h0;
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign wdata_ready = (r_state == S_WR_DATA);
    assign rdata_valid = (r_state == S_RD_OUT);
    assign rdata       = r_rdata;
    assign done        = (r_state == S_DONE);
    assign core_hold   = (r_state != S_IDLE);
    assign dram_a2     = r_dram_a2;
    assign dram_wd2    = r_dram_wd2;
    assign dram_we2    = r_dram_we2;
    assign iram_a2     = r_iram_a2;
    assign iram_wd2    = r_iram_wd2;
    assign iram_we2    = r_iram_we2;

endmodule

// File: tb/tb_debug_ram_sequencer.sv
// tb/tb_debug_ram_sequencer.sv - randomized self-checking bench for debug_ram_sequencer
module tb_debug_ram_sequencer;
    localparam int ADDR_W = 14;
    localparam int LEN_W  = 13;
    localparam int RD_LAT = 1;
    localparam int TMO    = 400;

    logic             CPU_CLK = 1'b0;
    logic             CPU_RST;
    logic             cmd_valid, cmd_ready, cmd_op, cmd_sel;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wdata_valid, wdata_ready, rdata_valid, rdata_ready, done, core_hold;
    logic [31:0]      wdata, rdata;
    logic [31:0]      dram_a2, dram_wd2, dram_rd2, iram_a2, iram_wd2, iram_rd2;
    logic [3:0]       dram_we2, iram_we2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ram_d [4096];
    logic [31:0] ram_i [4096];
    logic [31:0] ref_d [4096];
    logic [31:0] ref_i [4096];
    logic [31:0] rp_d [RD_LAT];
    logic [31:0] rp_i [RD_LAT];
    bit          ram_init = 1'b0;

    bit          log_sel [$];
    logic [31:0] log_a [$];
    logic [31:0] log_wd [$];
    time         log_t [$];
    int          we_bad, side_bad, wrdy_cnt, rvld_cnt;
    bit          mon_en = 1'b0;
    bit          cur_sel = 1'b0;
    logic [31:0] wq [$];

    debug_ram_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .done(done), .core_hold(core_hold),
        .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2), .dram_rd2(dram_rd2),
        .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2), .iram_rd2(iram_rd2)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    function automatic logic [31:0] init_word(input int sel, input int k);
        return 32'h5A00_0000 ^ (32'(sel) << 31) ^ (32'(k) * 32'h0001_9E37);
    endfunction

    // Two BRAMs with RD_LAT-cycle read latency and byte write enables
    always @(posedge CPU_CLK) begin
        if (!ram_init) begin
            for (int k = 0; k < 4096; k++) begin
                ram_d[k] <= init_word(0, k);
                ram_i[k] <= init_word(1, k);
            end
            ram_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (dram_we2[b]) ram_d[dram_a2[13:2]][8*b +: 8] <= dram_wd2[8*b +: 8];
                if (iram_we2[b]) ram_i[iram_a2[13:2]][8*b +: 8] <= iram_wd2[8*b +: 8];
            end
        end
        rp_d[0] <= ram_d[dram_a2[13:2]];
        rp_i[0] <= ram_i[iram_a2[13:2]];
        for (int k = 1; k < RD_LAT; k++) begin
            rp_d[k] <= rp_d[k-1];
            rp_i[k] <= rp_i[k-1];
        end
    end
    assign dram_rd2 = rp_d[RD_LAT-1];
    assign iram_rd2 = rp_i[RD_LAT-1];

    always @(negedge CPU_CLK) begin
        if (dram_we2 != 4'h0) begin
            log_sel.push_back(1'b0); log_a.push_back(dram_a2); log_wd.push_back(dram_wd2); log_t.push_back($time);
            if (dram_we2 != 4'hF) we_bad++;
        end
        if (iram_we2 != 4'h0) begin
            log_sel.push_back(1'b1); log_a.push_back(iram_a2); log_wd.push_back(iram_wd2); log_t.push_back($time);
            if (iram_we2 != 4'hF) we_bad++;
        end
        if (wdata_ready) wrdy_cnt++;
        if (rdata_valid) rvld_cnt++;
        if (mon_en && ((cur_sel ? (dram_a2 | dram_wd2 | {28'h0, dram_we2})
                                : (iram_a2 | iram_wd2 | {28'h0, iram_we2})) != 32'h0)) side_bad++;
    end

    task automatic clear_mon;
        log_sel.delete(); log_a.delete(); log_wd.delete(); log_t.delete();
        we_bad = 0; side_bad = 0; wrdy_cnt = 0; rvld_cnt = 0;
    endtask

    task automatic send_cmd(input bit op, input bit sel, input logic [31:0] addr, input int len);
        int w;
        cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_addr = addr; cmd_len = LEN_W'(len);
        w = 0;
        while (!cmd_ready && w < 20) begin @(negedge CPU_CLK); w++; end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_accept: cmd_ready=%b want 1", cmd_ready); end
        @(negedge CPU_CLK);
        cmd_valid = 1'b0; cmd_op = $urandom_range(0, 1); cmd_sel = $urandom_range(0, 1);
        cmd_addr = $urandom; cmd_len = LEN_W'($urandom);
    endtask

    task automatic do_write(input bit sel, input logic [31:0] addr, input int len, input bit dense);
        int n, cyc, ndone, idx;
        bit hs;
        logic [31:0] wd [$];
        wd = wq; wq.delete();
        while (wd.size() < len) wd.push_back($urandom);
        clear_mon(); cur_sel = sel; mon_en = 1'b1;
        send_cmd(1'b0, sel, addr, len);
        n = 0; cyc = 0; ndone = 0;
        while (cyc < TMO) begin
            if (done) begin ndone = 1; break; end
            if (!wdata_valid && n < len && (dense || $urandom_range(0, 2) != 0)) begin
                wdata_valid = 1'b1; wdata = wd[n];
            end
            hs = wdata_valid && wdata_ready;
            @(negedge CPU_CLK); cyc++;
            if (hs) begin n++; wdata_valid = 1'b0; wdata = $urandom; end
        end
        wdata_valid = 1'b0;
        n_cmp++;
        if (ndone !== 1) begin n_bad++; $display("FAIL wr_done: seen=%0d want 1 (words sent %0d)", ndone, n); end
        @(negedge CPU_CLK); mon_en = 1'b0;
        n_cmp++;
        if ({done, core_hold} !== 2'b00) begin n_bad++; $display("FAIL wr_release: done/core_hold=%b want 00", {done, core_hold}); end
        n_cmp++;
        if (log_a.size() !== len) begin n_bad++; $display("FAIL wr_pulses: got %0d want %0d", log_a.size(), len); end
        for (int i = 0; i < len && i < log_a.size(); i++) begin
            idx = int'(((addr >> 2) + 32'(i)) & 32'hFFF);
            n_cmp++;
            if (log_sel[i] !== sel || log_a[i] !== 32'(idx) << 2 || log_wd[i] !== wd[i]) begin
                n_bad++;
                $display("FAIL wr_word[%0d]: sel=%0d a2=%h wd2=%h want sel=%0d a2=%h wd2=%h",
                         i, log_sel[i], log_a[i], log_wd[i], sel, 32'(idx) << 2, wd[i]);
            end
            if (dense && i > 0) begin
                n_cmp++;
                if (log_t[i] - log_t[i-1] !== 20) begin n_bad++; $display("FAIL wr_rate: gap=%0t want 20", log_t[i] - log_t[i-1]); end
            end
        end
        for (int i = 0; i < len; i++) begin
            idx = int'(((addr >> 2) + 32'(i)) & 32'hFFF);
            if (sel) ref_i[idx] = wd[i]; else ref_d[idx] = wd[i];
        end
        n_cmp++;
        if (we_bad + side_bad + rvld_cnt !== 0) begin
            n_bad++; $display("FAIL wr_side: we_bad=%0d side_bad=%0d rvalid_cycles=%0d want 0/0/0", we_bad, side_bad, rvld_cnt);
        end
    endtask

    task automatic do_read(input bit sel, input logic [31:0] addr, input int len, input bit dense);
        int n, cyc, ndone, idx;
        time t_last;
        logic [31:0] exp_d;
        clear_mon(); cur_sel = sel; mon_en = 1'b1;
        send_cmd(1'b1, sel, addr, len);
        n = 0; cyc = 0; ndone = 0; t_last = 0;
        while (cyc < TMO) begin
            if (done) begin ndone = 1; break; end
            rdata_ready = dense || ($urandom_range(0, 1) == 1);
            wdata_valid = $urandom_range(0, 1);
            if (rdata_valid && rdata_ready) begin
                idx = int'(((addr >> 2) + 32'(n)) & 32'hFFF);
                exp_d = sel ? ref_i[idx] : ref_d[idx];
                n_cmp++;
                if (rdata !== exp_d) begin n_bad++; $display("FAIL rd_word[%0d]: rdata=%h want %h", n, rdata, exp_d); end
                if (dense && n > 0) begin
                    n_cmp++;
                    if ($time - t_last !== (2 + RD_LAT) * 10) begin
                        n_bad++; $display("FAIL rd_rate: gap=%0t want %0d", $time - t_last, (2 + RD_LAT) * 10);
                    end
                end
                t_last = $time; n++;
            end
            @(negedge CPU_CLK); cyc++;
        end
        rdata_ready = 1'b0; wdata_valid = 1'b0;
        n_cmp++;
        if (ndone !== 1 || n !== len) begin n_bad++; $display("FAIL rd_done: done_seen=%0d words=%0d want 1/%0d", ndone, n, len); end
        @(negedge CPU_CLK); mon_en = 1'b0;
        n_cmp++;
        if ({done, core_hold} !== 2'b00) begin n_bad++; $display("FAIL rd_release: done/core_hold=%b want 00", {done, core_hold}); end
        n_cmp++;
        if (log_a.size() + side_bad + wrdy_cnt !== 0) begin
            n_bad++; $display("FAIL rd_side: we_pulses=%0d side_bad=%0d wready_cycles=%0d want 0/0/0", log_a.size(), side_bad, wrdy_cnt);
        end
    endtask

    task automatic test_reset;
        CPU_RST = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_sel = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        repeat (3) @(negedge CPU_CLK);
        n_cmp++;
        if ({cmd_ready, core_hold, done, dram_we2, iram_we2} !== {1'b1, 10'b0}) begin
            n_bad++; $display("FAIL reset_hold: ready/hold/done/we=%b want 1 followed by zeros", {cmd_ready, core_hold, done, dram_we2, iram_we2});
        end
        CPU_RST = 1'b1;
        @(negedge CPU_CLK);
        n_cmp++;
        if ({cmd_ready, core_hold, done, wdata_ready, rdata_valid} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_ctrl: ready/hold/done/wready/rvalid=%b want 10000", {cmd_ready, core_hold, done, wdata_ready, rdata_valid});
        end
        n_cmp++;
        if ((rdata | dram_a2 | dram_wd2 | iram_a2 | iram_wd2) !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: or of rdata/a2/wd2=%h want 0", rdata | dram_a2 | dram_wd2 | iram_a2 | iram_wd2);
        end
    endtask

    task automatic test_write_read;
        wq = '{32'hA1, 32'hB2, 32'hC3};
        do_write(1'b0, 32'h10, 3, 1'b1);
        do_read(1'b0, 32'h10, 3, 1'b1);
    endtask

    task automatic test_read_stall;
        int w, bad;
        logic [31:0] hold_d, hold_a;
        clear_mon();
        send_cmd(1'b1, 1'b0, 32'h10, 2);
        rdata_ready = 1'b0; w = 0;
        while (!rdata_valid && w < 20) begin @(negedge CPU_CLK); w++; end
        hold_d = rdata; hold_a = dram_a2;
        n_cmp++;
        if (rdata_valid !== 1'b1 || hold_d !== ref_d[4]) begin
            n_bad++; $display("FAIL stall_first: rvalid=%b rdata=%h want 1/%h", rdata_valid, hold_d, ref_d[4]);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CPU_CLK);
            if (rdata_valid !== 1'b1 || rdata !== hold_d || dram_a2 !== hold_a) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL stall_hold: unstable cycles=%0d want 0", bad); end
        rdata_ready = 1'b1;
        @(negedge CPU_CLK);
        n_cmp++;
        if (dram_a2 !== 32'h14) begin n_bad++; $display("FAIL stall_next_a2: a2=%h want 00000014", dram_a2); end
        w = 0;
        while (!rdata_valid && w < 20) begin @(negedge CPU_CLK); w++; end
        n_cmp++;
        if (rdata_valid !== 1'b1 || rdata !== ref_d[5]) begin
            n_bad++; $display("FAIL stall_second: rvalid=%b rdata=%h want 1/%h", rdata_valid, rdata, ref_d[5]);
        end
        @(negedge CPU_CLK); rdata_ready = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done: done=%b want 1", done); end
        @(negedge CPU_CLK);
    endtask

    task automatic test_wrap;
        do_write(1'b1, 32'h3FFC, 2, 1'b1);
        do_read(1'b1, 32'h3FFC, 2, 1'b1);
    endtask

    task automatic test_zero_len;
        for (int op = 0; op < 2; op++) begin
            clear_mon();
            send_cmd(op[0], $urandom_range(0, 1), $urandom, 0);
            n_cmp++;
            if ({done, core_hold} !== 2'b11) begin n_bad++; $display("FAIL zero_done: op=%0d done/hold=%b want 11", op, {done, core_hold}); end
            @(negedge CPU_CLK);
            n_cmp++;
            if ({done, core_hold, cmd_ready} !== 3'b001) begin n_bad++; $display("FAIL zero_idle: op=%0d done/hold/ready=%b want 001", op, {done, core_hold, cmd_ready}); end
            n_cmp++;
            if (log_a.size() + wrdy_cnt + rvld_cnt !== 0) begin
                n_bad++; $display("FAIL zero_quiet: we=%0d wready=%0d rvalid=%0d want 0", log_a.size(), wrdy_cnt, rvld_cnt);
            end
        end
    endtask

    task automatic test_reset_mid;
        clear_mon();
        send_cmd(1'b0, 1'b0, 32'h200, 4);
        wdata_valid = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge CPU_CLK);
        wdata_valid = 1'b0;
        n_cmp++;
        if (dram_we2 !== 4'hF) begin n_bad++; $display("FAIL rst_commit: we2=%h want f", dram_we2); end
        #2 CPU_RST = 1'b0;
        #1;
        n_cmp++;
        if ({dram_we2, core_hold, cmd_ready, wdata_ready} !== 7'b0000010) begin
            n_bad++; $display("FAIL rst_async: we2/hold/ready/wready=%b want 0000010", {dram_we2, core_hold, cmd_ready, wdata_ready});
        end
        @(negedge CPU_CLK); CPU_RST = 1'b1;
        repeat (4) @(negedge CPU_CLK);
        n_cmp++;
        if ({cmd_ready, core_hold} !== 2'b10 || log_a.size() !== 1) begin
            n_bad++; $display("FAIL rst_after: ready/hold=%b we_pulses=%0d want 10/1", {cmd_ready, core_hold}, log_a.size());
        end
        do_read(1'b0, 32'h200, 1, 1'b1);
    endtask

    task automatic test_random;
        bit sel;
        logic [31:0] addr;
        int len;
        for (int it = 0; it < 6; it++) begin
            sel = $urandom_range(0, 1); addr = $urandom; len = $urandom_range(1, 6);
            do_write(sel, addr, len, 1'b0);
            do_read(sel, addr, len, 1'b0);
            do_read(!sel, $urandom, $urandom_range(1, 3), 1'b1);
        end
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) begin
            ref_d[k] = init_word(0, k);
            ref_i[k] = init_word(1, k);
        end
        test_reset();
        test_write_read();
        test_read_stall();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
